// File: rtl/obf_seq_ctrl_pkg.sv
// obf_seq_ctrl_pkg: shared widths, state encodings and types for the obfuscation sequencer.
// Width macros fall back to their usual defaults when the project defines header is not loaded first.
`ifndef OBF_PPC_WIDTH
`define OBF_PPC_WIDTH 3
`endif
`ifndef OBF_KEY_WIDTH
`define OBF_KEY_WIDTH 8
`endif
`ifndef OBF_SEQ_IDLE
`define OBF_SEQ_IDLE 1'b0
`endif
`ifndef OBF_SEQ_EXPAND
`define OBF_SEQ_EXPAND 1'b1
`endif
`ifndef OBF_SEQ_PPC_MAX
`define OBF_SEQ_PPC_MAX ((1 << `OBF_PPC_WIDTH) - 1)
`endif

package obf_seq_ctrl_pkg;
    localparam int OBF_PPC_W   = `OBF_PPC_WIDTH;
    localparam int OBF_KEY_W   = `OBF_KEY_WIDTH;
    localparam int OBF_PPC_MAX = `OBF_SEQ_PPC_MAX;
    typedef enum logic {
        SEQ_IDLE   = `OBF_SEQ_IDLE,
        SEQ_EXPAND = `OBF_SEQ_EXPAND
    } seq_state_e;
endpackage

// File: rtl/obf_seq_ctrl_if.sv
// obf_seq_if: fetch, generator and decode signals of the sequencer; slave is the sequencer side.
interface obf_seq_if #(
    parameter int PPC_WIDTH = `OBF_PPC_WIDTH,
    parameter int KEY_WIDTH = `OBF_KEY_WIDTH
);
    logic                 obf_en_i;
    logic [KEY_WIDTH-1:0] obf_key_i;
    logic [31:0]          if_insn_i;
    logic                 if_valid_i;
    logic                 if_ready_o;
    logic                 flush_i;
    logic [31:0]          gen_ref_o;
    logic [PPC_WIDTH-1:0] gen_ppc_o;
    logic [KEY_WIDTH-1:0] gen_key_o;
    logic                 gen_en_o;
    logic [31:0]          gen_insn_i;
    logic                 gen_last_i;
    logic                 gen_skip_i;
    logic [31:0]          id_insn_o;
    logic                 id_valid_o;
    logic                 id_skip_o;
    logic                 id_ready_i;
    logic                 seq_err_o;
    modport slave (
        input  obf_en_i, obf_key_i, if_insn_i, if_valid_i, flush_i,
        input  gen_insn_i, gen_last_i, gen_skip_i, id_ready_i,
        output if_ready_o, gen_ref_o, gen_ppc_o, gen_key_o, gen_en_o,
        output id_insn_o, id_valid_o, id_skip_o, seq_err_o
    );
    modport master (
        output obf_en_i, obf_key_i, if_insn_i, if_valid_i, flush_i,
        output gen_insn_i, gen_last_i, gen_skip_i, id_ready_i,
        input  if_ready_o, gen_ref_o, gen_ppc_o, gen_key_o, gen_en_o,
        input  id_insn_o, id_valid_o, id_skip_o, seq_err_o
    );
endinterface

// File: rtl/obf_seq_ctrl_outreg.sv
// obf_seq_outreg: single-entry valid/ready register holding the instruction and skip flag for decode.
module obf_seq_outreg (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [31:0] insn_i,
    input  logic        skip_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] insn_o,
    output logic        skip_o,
    output logic        slot_free_o
);
    logic        valid_q, valid_d;
    logic [31:0] insn_q, insn_d;
    logic        skip_q, skip_d;

    always_comb begin
        valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : ready_i ? 1'b0 : valid_q;
        insn_d  = load_i ? insn_i : insn_q;
        skip_d  = load_i ? skip_i : skip_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            insn_q  <= '0;
            skip_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            insn_q  <= insn_d;
            skip_q  <= skip_d;
        end
    end

    assign valid_o     = valid_q;
    assign insn_o      = insn_q;
    assign skip_o      = skip_q;
    assign slot_free_o = ~valid_q | ready_i;
endmodule

// File: rtl/obf_seq_ctrl.sv
// obf_seq_ctrl: holds one fetched reference and steps the generator ppc until the sequence ends.
// Define OBF_SEQ_PERF_EN to add saturating accepted-reference and issued-instruction counters.
module obf_seq_ctrl
    import obf_seq_ctrl_pkg::*;
#(
    parameter int PPC_WIDTH = `OBF_PPC_WIDTH,
    parameter int KEY_WIDTH = `OBF_KEY_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    obf_seq_if.slave    bus
`ifdef OBF_SEQ_PERF_EN
    ,
    output logic [31:0] perf_ref_cnt_o,
    output logic [31:0] perf_obf_cnt_o
`endif
);
    localparam logic [PPC_WIDTH-1:0] PPC_MAX = '1;

    seq_state_e           state_q, state_d;
    logic [PPC_WIDTH-1:0] ppc_q, ppc_d;
    logic [31:0]          ref_q, ref_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 en_q, en_d;
    logic                 err_q, err_d;
    logic                 expand, at_max, step_last, slot_free, if_ready, accept, step;

    always_comb begin
        expand    = state_q == SEQ_EXPAND;
        at_max    = ppc_q == PPC_MAX;
        step_last = bus.gen_last_i | ~en_q | at_max;
        if_ready  = ~rst & ~bus.flush_i & (~expand | (slot_free & step_last));
        accept    = bus.if_valid_i & if_ready;
        step      = expand & slot_free & ~bus.flush_i;
        state_d   = state_q;
        ppc_d     = ppc_q;
        ref_d     = ref_q;
        key_d     = key_q;
        en_d      = en_q;
        err_d     = err_q | (step & at_max & ~bus.gen_last_i & en_q);
        if (bus.flush_i) begin
            state_d = SEQ_IDLE;
            ppc_d   = '0;
        end else begin
            if (step) begin
                state_d = step_last ? SEQ_IDLE : state_q;
                ppc_d   = step_last ? ppc_q : ppc_q + 1'b1;
            end
            // A new reference may land on the final step, giving back-to-back sequences
            if (accept) begin
                state_d = SEQ_EXPAND;
                ppc_d   = '0;
                ref_d   = bus.if_insn_i;
                key_d   = bus.obf_key_i;
                en_d    = bus.obf_en_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
            ppc_q   <= '0;
            ref_q   <= '0;
            key_q   <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ppc_q   <= ppc_d;
            ref_q   <= ref_d;
            key_q   <= key_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end

    obf_seq_outreg u_outreg (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (bus.flush_i),
        .load_i      (step),
        .insn_i      (bus.gen_insn_i),
        .skip_i      (bus.gen_skip_i),
        .ready_i     (bus.id_ready_i),
        .valid_o     (bus.id_valid_o),
        .insn_o      (bus.id_insn_o),
        .skip_o      (bus.id_skip_o),
        .slot_free_o (slot_free)
    );

    assign bus.if_ready_o = if_ready;
    assign bus.gen_ref_o  = ref_q;
    assign bus.gen_ppc_o  = ppc_q;
    assign bus.gen_key_o  = key_q;
    assign bus.gen_en_o   = en_q;
    assign bus.seq_err_o  = err_q;

`ifdef OBF_SEQ_PERF_EN
    logic [31:0] ref_cnt_q, ref_cnt_d, obf_cnt_q, obf_cnt_d;

    always_comb begin
        ref_cnt_d = ref_cnt_q + {31'b0, accept & ~&ref_cnt_q};
        obf_cnt_d = obf_cnt_q + {31'b0, step & ~&obf_cnt_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt_q <= '0;
            obf_cnt_q <= '0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            obf_cnt_q <= obf_cnt_d;
        end
    end

    assign perf_ref_cnt_o = ref_cnt_q;
    assign perf_obf_cnt_o = obf_cnt_q;
`endif
endmodule

// File: tb/tb_obf_seq_ctrl.sv
// tb_obf_seq_ctrl: directed stimulus with a queue scoreboard checked by a decode-side monitor.
module tb_obf_seq_ctrl;
    typedef struct {
        logic [31:0] insn;
        logic        skip;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   gen_last_at = 99;
    exp_t sb_q[$];

    obf_seq_if #(.PPC_WIDTH(3), .KEY_WIDTH(8)) bus ();
`ifdef OBF_SEQ_PERF_EN
    logic [31:0] perf_ref, perf_obf;
`endif

    obf_seq_ctrl #(.PPC_WIDTH(3), .KEY_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef OBF_SEQ_PERF_EN
        ,
        .perf_ref_cnt_o (perf_ref),
        .perf_obf_cnt_o (perf_obf)
`endif
    );

    always #5 clk = ~clk;

    // Generator model: XOR with replicated key and step index, last at a chosen ppc
    always_comb begin
        bus.gen_insn_i = bus.gen_en_o ? (bus.gen_ref_o ^ {4{bus.gen_key_o}} ^ {29'b0, bus.gen_ppc_o}) : bus.gen_ref_o;
        bus.gen_last_i = bus.gen_en_o && (int'(bus.gen_ppc_o) == gen_last_at);
        bus.gen_skip_i = bus.gen_en_o & bus.gen_ppc_o[0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] insn, input logic en, input logic [7:0] key);
        bus.if_valid_i = 1'b1;
        bus.if_insn_i  = insn;
        bus.obf_en_i   = en;
        bus.obf_key_i  = key;
    endtask

    task automatic push(input logic [31:0] insn, input logic skip);
        exp_t e;
        e.insn = insn;
        e.skip = skip;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.id_valid_o && bus.id_ready_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL id_unexpected: got %h expected none", bus.id_insn_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("id_insn", bus.id_insn_o, e.insn);
                chk("id_skip", {31'b0, bus.id_skip_o}, {31'b0, e.skip});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.if_valid_i = 1'b0;
        bus.if_insn_i  = '0;
        bus.obf_en_i   = 1'b0;
        bus.obf_key_i  = '0;
        bus.flush_i    = 1'b0;
        bus.id_ready_i = 1'b1;
        repeat (3) tick();
        chk("rst_id_valid", {31'b0, bus.id_valid_o}, 32'd0);
        chk("rst_id_insn", bus.id_insn_o, 32'd0);
        chk("rst_gen_ref", bus.gen_ref_o, 32'd0);
        chk("rst_gen_key", {24'b0, bus.gen_key_o}, 32'd0);
        chk("rst_gen_ppc", {29'b0, bus.gen_ppc_o}, 32'd0);
        chk("rst_seq_err", {31'b0, bus.seq_err_o}, 32'd0);
        chk("rst_if_ready", {31'b0, bus.if_ready_o}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_if_ready", {31'b0, bus.if_ready_o}, 32'd1);

        // Passthrough: one step, reference forwarded unchanged
        send(32'h9C210004, 1'b0, 8'h00);
        push(32'h9C210004, 1'b0);
        tick();
        bus.if_valid_i = 1'b0;
        chk("pt_if_ready", {31'b0, bus.if_ready_o}, 32'd1);
        chk("pt_valid_lat", {31'b0, bus.id_valid_o}, 32'd0);
        tick();
        chk("pt_id_valid", {31'b0, bus.id_valid_o}, 32'd1);
        chk("pt_id_insn", bus.id_insn_o, 32'h9C210004);
        tick();
        chk("pt_drain", {31'b0, bus.id_valid_o}, 32'd0);

        // Three-step sequence then back-to-back passthrough accept on the last step
        gen_last_at = 2;
        send(32'h12345678, 1'b1, 8'h5A);
        push(32'h486E0C22, 1'b0);
        push(32'h486E0C23, 1'b1);
        push(32'h486E0C20, 1'b0);
        tick();
        send(32'hCAFEF00D, 1'b0, 8'h00);
        chk("seq_stall_p0", {31'b0, bus.if_ready_o}, 32'd0);
        chk("seq_ppc0", {29'b0, bus.gen_ppc_o}, 32'd0);
        tick();
        chk("seq_stall_p1", {31'b0, bus.if_ready_o}, 32'd0);
        chk("seq_ppc1", {29'b0, bus.gen_ppc_o}, 32'd1);
        tick();
        chk("seq_ppc2", {29'b0, bus.gen_ppc_o}, 32'd2);
        chk("seq_b2b_ready", {31'b0, bus.if_ready_o}, 32'd1);
        push(32'hCAFEF00D, 1'b0);
        tick();
        bus.if_valid_i = 1'b0;
        chk("b2b_gen_ref", bus.gen_ref_o, 32'hCAFEF00D);
        chk("b2b_gen_en", {31'b0, bus.gen_en_o}, 32'd0);
        chk("b2b_ppc", {29'b0, bus.gen_ppc_o}, 32'd0);
        chk("b2b_id_insn", bus.id_insn_o, 32'h486E0C20);
        repeat (2) tick();

        // Back-pressure for three cycles plus key change mid-sequence
        gen_last_at = 3;
        send(32'h0F0F0F0F, 1'b1, 8'h5A);
        push(32'h55555555, 1'b0);
        push(32'h55555554, 1'b1);
        push(32'h55555557, 1'b0);
        push(32'h55555556, 1'b1);
        tick();
        bus.if_valid_i = 1'b0;
        tick();
        bus.obf_key_i  = 8'hA5;
        bus.id_ready_i = 1'b0;
        chk("key_hold", {24'b0, bus.gen_key_o}, 32'h5A);
        chk("bp_ppc", {29'b0, bus.gen_ppc_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_id_insn", bus.id_insn_o, 32'h55555555);
            chk("bp_ppc_hold", {29'b0, bus.gen_ppc_o}, 32'd1);
            chk("bp_key_hold", {24'b0, bus.gen_key_o}, 32'h5A);
        end
        bus.id_ready_i = 1'b1;
        repeat (3) tick();
        chk("bp_end_insn", bus.id_insn_o, 32'h55555556);
        chk("bp_end_key", {24'b0, bus.gen_key_o}, 32'h5A);
        chk("bp_end_ready", {31'b0, bus.if_ready_o}, 32'd1);
        tick();

        // Runaway: generator never signals last, forced stop at ppc 7
        gen_last_at = 99;
        send(32'hA0000000, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) push(32'hA0000000 | i, i[0]);
        tick();
        bus.if_valid_i = 1'b0;
        repeat (7) tick();
        chk("run_ppc_max", {29'b0, bus.gen_ppc_o}, 32'd7);
        chk("run_err_pre", {31'b0, bus.seq_err_o}, 32'd0);
        tick();
        chk("run_err", {31'b0, bus.seq_err_o}, 32'd1);
        chk("run_idle", {31'b0, bus.if_ready_o}, 32'd1);
        chk("run_last_insn", bus.id_insn_o, 32'hA0000007);
        tick();

        // Flush mid-sequence discards the held step; error flag survives
        send(32'h11110000, 1'b1, 8'h00);
        tick();
        bus.if_valid_i = 1'b0;
        tick();
        chk("fl_ppc", {29'b0, bus.gen_ppc_o}, 32'd1);
        chk("fl_valid_pre", {31'b0, bus.id_valid_o}, 32'd1);
        bus.flush_i    = 1'b1;
        bus.id_ready_i = 1'b0;
        #1;
        chk("fl_if_ready", {31'b0, bus.if_ready_o}, 32'd0);
        tick();
        bus.flush_i = 1'b0;
        #1;
        chk("fl_valid", {31'b0, bus.id_valid_o}, 32'd0);
        chk("fl_ppc0", {29'b0, bus.gen_ppc_o}, 32'd0);
        chk("fl_idle", {31'b0, bus.if_ready_o}, 32'd1);
        chk("fl_err", {31'b0, bus.seq_err_o}, 32'd1);
        bus.id_ready_i = 1'b1;

        // Reset with flush clears the sticky error
        rst = 1'b1;
        bus.flush_i = 1'b1;
        tick();
        rst = 1'b0;
        bus.flush_i = 1'b0;
        chk("rstfl_err", {31'b0, bus.seq_err_o}, 32'd0);
        chk("rstfl_valid", {31'b0, bus.id_valid_o}, 32'd0);
        repeat (3) tick();
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/obf_seq_ctrl.md
Name: obf_seq_ctrl

Overview:
- Sequencer for the obfuscated instruction generator. It sits between fetch and decode.
- It accepts one reference instruction from fetch and holds it. It then steps the substitution pseudo-PC (ppc) so the generator emits the full substitution sequence, one instruction per decode slot.
- It latches key and enable per sequence, stalls fetch until the last step is issued, and handles decode back-pressure, flush and runaway sequences.

Parameters:
- PPC_WIDTH, 3 (= `OBF_PPC_WIDTH): width of the substitution step index.
- KEY_WIDTH, 8 (= `OBF_KEY_WIDTH): width of the obfuscation key.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- obf_en_i  in  1  obfuscation enable; sampled at sequence start.
- obf_key_i  in  KEY_WIDTH  key; sampled at sequence start.
- if_insn_i  in  32  reference instruction from fetch.
- if_valid_i  in  1  fetch instruction valid.
- if_ready_o  out  1  controller accepts if_insn_i this cycle.
- flush_i  in  1  branch/exception flush; discards held and queued work.
- gen_ref_o  out  32  held reference instruction to generator.
- gen_ppc_o  out  PPC_WIDTH  current step to generator.
- gen_key_o  out  KEY_WIDTH  latched key to generator.
- gen_en_o  out  1  latched enable to generator.
- gen_insn_i  in  32  generator output instruction.
- gen_last_i  in  1  generator marks final step.
- gen_skip_i  in  1  generator step carries LUT immediate.
- id_insn_o  out  32  registered instruction to decode.
- id_valid_o  out  1  id_insn_o valid.
- id_skip_o  out  1  registered gen_skip_i aligned with id_insn_o.
- id_ready_i  in  1  decode accepts this cycle.
- seq_err_o  out  1  sticky: sequence overran the maximum ppc.

Behaviour:
- States: IDLE (nothing held) and EXPAND (reference held, steps pending).
- Reset values: state=IDLE, ppc=0, gen_ref_o=0, gen_key_o=0, gen_en_o=0, id_valid_o=0, id_insn_o=0, id_skip_o=0, seq_err_o=0.
- slot_free = ~id_valid_o | id_ready_i.
- if_ready_o = (state==IDLE) | (state==EXPAND & slot_free & step_last). Combinational; 0 while rst or flush_i.
- Accept (if_valid_i & if_ready_o):
  - register if_insn_i into gen_ref_o, obf_key_i into gen_key_o, obf_en_i into gen_en_o;
  - set ppc=0 and state=EXPAND.
- EXPAND with slot_free:
  - capture gen_insn_i/gen_skip_i into id_insn_o/id_skip_o and set id_valid_o=1;
  - if step_last: go to IDLE, or reload directly if a new instruction is accepted that same cycle (back-to-back, no bubble);
  - otherwise ppc=ppc+1.
- EXPAND without slot_free: hold all state; id outputs stable.
- step_last = gen_last_i | ~gen_en_o | (ppc == 2^PPC_WIDTH-1).
  - Forced last at max ppc sets seq_err_o=1. seq_err_o stays set until rst.
- id_valid_o clears when id_ready_i=1 and no new step is captured that cycle.
- Latency: instruction accepted at edge N → first obf instruction on id_insn_o after edge N+1. Sustained throughput is one instruction per cycle.
- gen_en_o=0 (passthrough): exactly one step, id_insn_o = gen_insn_i (generator passes ref through).
- Changing obf_en_i or obf_key_i mid-sequence has no effect until the next accept.
- flush_i (synchronous, priority below rst): state=IDLE, ppc=0, id_valid_o=0. No accept occurs that cycle. seq_err_o is unaffected.
- rst and flush both asserted: rst wins (identical result, except seq_err_o clears).
- ppc arithmetic is unsigned and never wraps; forced last stops it at max.

Optional Feature:
- OBF_SEQ_PERF_EN.
- Defined: adds outputs perf_ref_cnt_o[31:0] (accepted references) and perf_obf_cnt_o[31:0] (instructions captured to id). Both clear on rst, saturate at 2^32-1, and are unaffected by flush.
- Undefined: ports and logic are absent.

Decomposition:
- Add to obf_defines.v:
  - state encodings OBF_SEQ_IDLE and OBF_SEQ_EXPAND;
  - OBF_SEQ_PPC_MAX.
- Parameter defaults come from the existing PPC/KEY width macros.
- One natural sub-module: obf_seq_outreg, the single-entry valid/ready output register for insn and skip.

Test Plan:
- Reset then if_valid_i=1, insn 0x9C210004, obf_en_i=0 → one id_insn_o=0x9C210004 two edges after accept; if_ready_o=1 in the following cycle.
- obf_en_i=1, generator model returns last at ppc=2 → three id instructions with gen_ppc_o=0,1,2. if_ready_o=0 during ppc 0–1, then a back-to-back accept on the ppc=2 cycle.
- id_ready_i=0 for 3 cycles mid-sequence → id_insn_o, ppc and gen_key_o hold; the sequence resumes with no lost or duplicate step.
- Key change 0x5A→0xA5 at ppc=1 → gen_key_o stays 0x5A until the next accept.
- Generator never asserts last, PPC_WIDTH=3 → 8 instructions issued, seq_err_o=1 after the 8th, then IDLE.
- flush_i at ppc=1 with id_valid_o=1 → next cycle id_valid_o=0, state IDLE, if_ready_o=1; seq_err_o unchanged.
